stack_data_memory: RTL and testbench

Word-addressed data memory with a hardware stack pointer, serving as the storage backend directly downstream of the memory stage. It executes one command per cycle (read, write, push or pop), returns read/pop data registered one cycle later, and tracks the stack pointer, occupancy and sticky overflow/underflow errors. The stack grows downward from the top word of the array into a reserved region; the rest of the array is general data memory.

---
 rtl/stack_data_memory.sv | 84 ++++++++
 tb/tb_stack_data_memory.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/stack_data_memory.sv
// stack_data_memory: word memory with a downward-growing hardware stack in its upper region
module stack_data_memory #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int STACK_BASE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic              memory_push,
  input  logic              memory_pop,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data_r,
  output logic              data_valid_r,
  output logic [ADDR_W-1:0] sp_r,
  output logic [ADDR_W-1:0] stack_count_r,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              overflow_r,
  output logic              underflow_r
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_TOP  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SP_FULL = ADDR_W'(STACK_BASE - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] sp_q, sp_d, cnt_q, cnt_d, addr, wr_addr, rd_addr;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic              pop_sel, wr_sel, rd_sel, push_ok, pop_ok, we, re;
  logic              unused_addr;
  assign unused_addr   = ^address[15:ADDR_W];
  assign stack_empty   = sp_q == SP_TOP;
  assign stack_full    = sp_q == SP_FULL;
  assign data_r        = data_q;
  assign data_valid_r  = valid_q;
  assign sp_r          = sp_q;
  assign stack_count_r = cnt_q;
  assign overflow_r    = ovf_q;
  assign underflow_r   = unf_q;
  // command arbitration (push > pop > write > read) and next-state computation
  always_comb begin
    addr    = address[ADDR_W-1:0];
    pop_sel = !memory_push && memory_pop;
    wr_sel  = !memory_push && !memory_pop && memory_write;
    rd_sel  = !memory_push && !memory_pop && !memory_write && memory_read;
    push_ok = memory_push && !stack_full;
    pop_ok  = pop_sel && !stack_empty;
    we      = push_ok || wr_sel;
    wr_addr = push_ok ? sp_q : addr;
    re      = pop_ok || rd_sel;
    rd_addr = pop_ok ? sp_q + ONE : addr;
    sp_d    = push_ok ? sp_q - ONE : pop_ok ? sp_q + ONE : sp_q;
    cnt_d   = push_ok ? cnt_q + ONE : pop_ok ? cnt_q - ONE : cnt_q;
    data_d  = re ? mem_q[rd_addr] : data_q;
    valid_d = re;
    ovf_d   = ovf_q || (memory_push && stack_full);
    unf_d   = unf_q || (pop_sel && stack_empty);
  end
  // control state and registered read data, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q    <= SP_TOP;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // storage array is never reset; one write port shared by store and push
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= write_data;
  end
endmodule

// File: tb/tb_stack_data_memory.sv
// tb_stack_data_memory: table vectors, corner sequences and random stimulus against a stack model
module tb_stack_data_memory;
  localparam int DEPTH = 2048;
  localparam int CAP   = DEPTH - 1024;
  logic        clk = 1'b0, rst = 1'b0;
  logic        memory_read = 1'b0, memory_write = 1'b0, memory_push = 1'b0, memory_pop = 1'b0;
  logic [15:0] address = '0, write_data = '0;
  logic [15:0] data_r;
  logic        data_valid_r, stack_empty, stack_full, overflow_r, underflow_r;
  logic [10:0] sp_r, stack_count_r;
  int          checks = 0, errors = 0;
  logic [15:0] m_mem [DEPTH];
  int          m_cnt;
  logic [15:0] m_data;
  logic        m_valid, m_ovf, m_unf;

  typedef struct {
    logic push, pop, wr, rd;
    logic [15:0] a, wd, exp_data;
    logic exp_valid;
    logic [10:0] exp_sp;
    logic exp_unf;
  } vec_t;
  vec_t vecs [13];

  stack_data_memory dut (
    .clk(clk), .rst(rst), .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop), .address(address),
    .write_data(write_data), .data_r(data_r), .data_valid_r(data_valid_r), .sp_r(sp_r),
    .stack_count_r(stack_count_r), .stack_empty(stack_empty), .stack_full(stack_full),
    .overflow_r(overflow_r), .underflow_r(underflow_r)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " data_r"}, 32'(data_r), 32'(m_data));
    chk({tag, " data_valid_r"}, 32'(data_valid_r), 32'(m_valid));
    chk({tag, " sp_r"}, 32'(sp_r), 32'(DEPTH - 1 - m_cnt));
    chk({tag, " stack_count_r"}, 32'(stack_count_r), 32'(m_cnt));
    chk({tag, " stack_empty"}, 32'(stack_empty), 32'(m_cnt == 0));
    chk({tag, " stack_full"}, 32'(stack_full), 32'(m_cnt == CAP));
    chk({tag, " overflow_r"}, 32'(overflow_r), 32'(m_ovf));
    chk({tag, " underflow_r"}, 32'(underflow_r), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic push, pop, wr, rd, input logic [15:0] a, wd);
    int ai;
    ai = int'(a) % DEPTH;
    m_valid = 1'b0;
    if (push) begin
      if (m_cnt == CAP) m_ovf = 1'b1;
      else begin m_mem[DEPTH - 1 - m_cnt] = wd; m_cnt++; end
    end else if (pop) begin
      if (m_cnt == 0) m_unf = 1'b1;
      else begin m_data = m_mem[DEPTH - m_cnt]; m_cnt--; m_valid = 1'b1; end
    end else if (wr) m_mem[ai] = wd;
    else if (rd) begin m_data = m_mem[ai]; m_valid = 1'b1; end
  endtask

  task automatic step(input logic push, pop, wr, rd, input logic [15:0] a, wd, input string tag);
    @(negedge clk);
    memory_push = push; memory_pop = pop; memory_write = wr; memory_read = rd;
    address = a; write_data = wd;
    @(posedge clk);
    model_step(push, pop, wr, rd, a, wd);
    #1 check_all(tag);
  endtask

  initial begin
    logic [15:0] saved;
    vecs[0]  = '{0, 0, 1, 0, 16'd5,      16'hBEEF, 16'h0000, 0, 11'd2047, 0};
    vecs[1]  = '{0, 0, 0, 1, 16'd5,      16'h0000, 16'hBEEF, 1, 11'd2047, 0};
    vecs[2]  = '{0, 0, 0, 0, 16'd0,      16'h0000, 16'hBEEF, 0, 11'd2047, 0};
    vecs[3]  = '{1, 0, 0, 0, 16'd0,      16'h1111, 16'hBEEF, 0, 11'd2046, 0};
    vecs[4]  = '{1, 0, 0, 0, 16'd0,      16'h2222, 16'hBEEF, 0, 11'd2045, 0};
    vecs[5]  = '{0, 1, 0, 0, 16'd0,      16'h0000, 16'h2222, 1, 11'd2046, 0};
    vecs[6]  = '{0, 1, 0, 0, 16'd0,      16'h0000, 16'h1111, 1, 11'd2047, 0};
    vecs[7]  = '{0, 1, 0, 0, 16'd0,      16'h0000, 16'h1111, 0, 11'd2047, 1};
    vecs[8]  = '{1, 0, 0, 1, 16'd5,      16'h3333, 16'h1111, 0, 11'd2046, 1};
    vecs[9]  = '{0, 1, 1, 0, 16'd5,      16'h0000, 16'h3333, 1, 11'd2047, 1};
    vecs[10] = '{0, 0, 1, 1, 16'd7,      16'h0A0A, 16'h3333, 0, 11'd2047, 1};
    vecs[11] = '{0, 0, 0, 1, 16'hF807,   16'h0000, 16'h0A0A, 1, 11'd2047, 1};
    vecs[12] = '{0, 0, 0, 1, 16'd5,      16'h0000, 16'hBEEF, 1, 11'd2047, 1};
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table data_r", i), 32'(data_r), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d table valid", i), 32'(data_valid_r), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d table sp_r", i), 32'(sp_r), 32'(vecs[i].exp_sp));
      chk($sformatf("vec%0d table underflow", i), 32'(underflow_r), 32'(vecs[i].exp_unf));
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 16'(i), 16'($urandom), "prefill");
    while (m_cnt < CAP) step(1, 0, 0, 0, 16'd0, 16'($urandom), "fill");
    chk("full stack_full", 32'(stack_full), 32'd1);
    chk("full sp_r", 32'(sp_r), 32'd1023);
    saved = m_mem[1023];
    step(1, 0, 0, 0, 16'd0, ~saved, "overpush");
    chk("overpush overflow_r", 32'(overflow_r), 32'd1);
    chk("overpush sp_r", 32'(sp_r), 32'd1023);
    step(0, 0, 0, 1, 16'd1023, 16'd0, "read1023");
    chk("mem1023 unchanged", 32'(data_r), 32'(saved));
    step(0, 1, 0, 0, 16'd0, 16'd0, "pop_from_full");
    @(negedge clk);
    memory_pop = 1'b0; memory_read = 1'b0;
    rst = 1'b0;
    #1 model_reset();
    check_all("reset2");
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), "rand");
    step(1, 0, 0, 0, 16'd0, 16'h5A5A, "pre_pop");
    step(0, 1, 0, 0, 16'd0, 16'd0, "mid_pop");
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("reset_mid_pop");
    chk("reset_mid_pop valid", 32'(data_valid_r), 32'd0);
    chk("reset_mid_pop sp_r", 32'(sp_r), 32'd2047);
    @(negedge clk);
    memory_pop = 1'b0;
    rst = 1'b1;
    step(0, 0, 0, 0, 16'd0, 16'd0, "idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
